// File: rtl/tournament_bp_if.sv
// Lookup/update bundle between the pipeline and the tournament predictor.
// The predictor takes the slave view; the pipeline or bench takes the master view.
interface tournament_bp_if #(
    parameter int PHT_DEPTH = 7,
    parameter int PERF_W    = 32
);
    localparam int META_W = 3 * PHT_DEPTH + 2;

    logic [1:0]        mode;
    logic [31:0]       pc_f;
    logic              lookup_f;
    logic              pred_taken_f;
    logic [META_W-1:0] meta_f;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic              upd_pred;
    logic [META_W-1:0] upd_meta;
    logic              mispredict;
    logic [PERF_W-1:0] perf_lookup;
    logic [PERF_W-1:0] perf_branch;
    logic [PERF_W-1:0] perf_miss;

    modport slave (
        input  mode, pc_f, lookup_f,
        input  upd_valid, upd_pc, upd_taken, upd_pred, upd_meta,
        output pred_taken_f, meta_f, mispredict,
        output perf_lookup, perf_branch, perf_miss
    );

    modport master (
        output mode, pc_f, lookup_f,
        output upd_valid, upd_pc, upd_taken, upd_pred, upd_meta,
        input  pred_taken_f, meta_f, mispredict,
        input  perf_lookup, perf_branch, perf_miss
    );
endinterface

// File: rtl/tournament_bp.sv
// Tournament direction predictor: gshare + two-level local + chooser.
// Combinational F-stage lookup, M-stage update driven by carried metadata.
module tournament_bp #(
    parameter int PHT_DEPTH = 7,
    parameter int GHR_W     = 7,
    parameter int BHT_DEPTH = 3,
    parameter int CTR_W     = 2,
    parameter int PERF_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    tournament_bp_if.slave  bp
);
    localparam int PHT_N  = 1 << PHT_DEPTH;
    localparam int BHT_N  = 1 << BHT_DEPTH;
    localparam int META_W = 3 * PHT_DEPTH + 2;
    localparam logic [CTR_W-1:0] WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0]     r_gpht [PHT_N];
    logic [CTR_W-1:0]     r_lpht [PHT_N];
    logic [CTR_W-1:0]     r_cho  [PHT_N];
    logic [PHT_DEPTH-1:0] r_bht  [BHT_N];
    logic [GHR_W-1:0]     r_ghr;
    logic [PERF_W-1:0]    r_plook;
    logic [PERF_W-1:0]    r_pbr;
    logic [PERF_W-1:0]    r_pmiss;

    logic [PHT_DEPTH-1:0] w_cidx;
    logic [PHT_DEPTH-1:0] w_gidx;
    logic [PHT_DEPTH-1:0] w_lidx;
    logic                 w_pg;
    logic                 w_pl;
    logic                 w_choice;
    logic                 w_pred;
    logic [PHT_DEPTH-1:0] w_ugidx;
    logic [PHT_DEPTH-1:0] w_ulidx;
    logic [PHT_DEPTH-1:0] w_ucidx;
    logic                 w_upg;
    logic                 w_upl;
    logic [BHT_DEPTH-1:0] w_ubidx;
    logic                 w_miss;
    logic                 w_unused;

    function automatic logic [CTR_W-1:0] f_sat(
        input logic [CTR_W-1:0] c,
        input logic             up
    );
        logic [CTR_W-1:0] r;
        r = c;
        if (up && !(&c))
            r = c + CTR_W'(1);
        else if (!up && (|c))
            r = c - CTR_W'(1);
        return r;
    endfunction

    assign w_cidx   = bp.pc_f[PHT_DEPTH+1:2];
    assign w_gidx   = w_cidx ^ PHT_DEPTH'(r_ghr);
    assign w_lidx   = r_bht[bp.pc_f[BHT_DEPTH+1:2]];
    assign w_pg     = r_gpht[w_gidx][CTR_W-1];
    assign w_pl     = r_lpht[w_lidx][CTR_W-1];
    assign w_choice = r_cho[w_cidx][CTR_W-1];

    always_comb begin
        w_pred = 1'b0;
        case (bp.mode)
            2'b00:   w_pred = w_choice ? w_pl : w_pg;
            2'b01:   w_pred = w_pg;
            2'b10:   w_pred = w_pl;
            default: w_pred = 1'b0;
        endcase
    end

    assign bp.pred_taken_f = w_pred;
    assign bp.meta_f       = {w_gidx, w_lidx, w_cidx, w_pg, w_pl};

    // Update indices come only from the carried metadata, never from live state.
    assign w_ugidx = bp.upd_meta[META_W-1 -: PHT_DEPTH];
    assign w_ulidx = bp.upd_meta[2*PHT_DEPTH+1 -: PHT_DEPTH];
    assign w_ucidx = bp.upd_meta[PHT_DEPTH+1 -: PHT_DEPTH];
    assign w_upg   = bp.upd_meta[1];
    assign w_upl   = bp.upd_meta[0];
    assign w_ubidx = bp.upd_pc[BHT_DEPTH+1:2];
    assign w_miss  = bp.upd_valid & (bp.upd_taken ^ bp.upd_pred);

    assign bp.mispredict = w_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_N; i++) begin
                r_gpht[i] <= WNT;
                r_lpht[i] <= WNT;
                r_cho[i]  <= WNT;
            end
            for (int i = 0; i < BHT_N; i++)
                r_bht[i] <= '0;
            r_ghr <= '0;
        end else if (bp.upd_valid) begin
            r_gpht[w_ugidx] <= f_sat(r_gpht[w_ugidx], bp.upd_taken);
            r_lpht[w_ulidx] <= f_sat(r_lpht[w_ulidx], bp.upd_taken);
            r_bht[w_ubidx]  <= PHT_DEPTH'({r_bht[w_ubidx], bp.upd_taken});
            r_ghr           <= GHR_W'({r_ghr, bp.upd_taken});
            if (w_upg != w_upl)
                r_cho[w_ucidx] <= f_sat(r_cho[w_ucidx],
                                        w_upl == bp.upd_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plook <= '0;
            r_pbr   <= '0;
            r_pmiss <= '0;
        end else begin
            if (bp.lookup_f && !(&r_plook))
                r_plook <= r_plook + PERF_W'(1);
            if (bp.upd_valid && !(&r_pbr))
                r_pbr <= r_pbr + PERF_W'(1);
            if (w_miss && !(&r_pmiss))
                r_pmiss <= r_pmiss + PERF_W'(1);
        end
    end

    assign bp.perf_lookup = r_plook;
    assign bp.perf_branch = r_pbr;
    assign bp.perf_miss   = r_pmiss;

    assign w_unused = ^{bp.pc_f[31:PHT_DEPTH+2], bp.pc_f[1:0],
                        bp.upd_pc[31:BHT_DEPTH+2], bp.upd_pc[1:0]};
endmodule

// File: tb/tb_tournament_bp.sv
// Bench for tournament_bp: array-based reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_tournament_bp;
    localparam int PD   = 7;
    localparam int GW   = 7;
    localparam int BD   = 3;
    localparam int CW   = 2;
    localparam int PW   = 4;
    localparam int MW   = 3 * PD + 2;
    localparam int NP   = 1 << PD;
    localparam int NB   = 1 << BD;
    localparam int CMAX = (1 << CW) - 1;
    localparam int WNT  = (1 << (CW - 1)) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tournament_bp_if #(.PHT_DEPTH(PD), .PERF_W(PW)) bp ();

    tournament_bp #(
        .PHT_DEPTH(PD), .GHR_W(GW), .BHT_DEPTH(BD),
        .CTR_W(CW), .PERF_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bp(bp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int gp [NP];
    int lp [NP];
    int ch [NP];
    int bh [NB];
    int ghr;
    int m_look, m_br, m_miss;

    function automatic void model_look(input logic [31:0] pc,
                                       input logic [1:0] md,
                                       output logic [MW-1:0] m,
                                       output logic p);
        int c, g, l;
        logic pg, pl, sel;
        c   = int'(pc >> 2) % NP;
        g   = c ^ ghr;
        l   = bh[int'(pc >> 2) % NB];
        pg  = gp[g] > WNT;
        pl  = lp[l] > WNT;
        sel = ch[c] > WNT;
        m   = {PD'(g), PD'(l), PD'(c), pg, pl};
        if (md == 2'd0)      p = sel ? pl : pg;
        else if (md == 2'd1) p = pg;
        else if (md == 2'd2) p = pl;
        else                 p = 1'b0;
    endfunction

    function automatic int bump(input int v, input logic up);
        if (up) return (v < CMAX) ? v + 1 : CMAX;
        return (v > 0) ? v - 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                gp[i] <= WNT;
                lp[i] <= WNT;
                ch[i] <= WNT;
            end
            for (int i = 0; i < NB; i++) bh[i] <= 0;
            ghr    <= 0;
            m_look <= 0;
            m_br   <= 0;
            m_miss <= 0;
        end else begin
            if (bp.lookup_f && m_look < PMAX) m_look <= m_look + 1;
            if (bp.upd_valid) begin
                int g, l, c, b;
                logic t, pg, pl;
                t  = bp.upd_taken;
                g  = int'(bp.upd_meta[MW-1 -: PD]);
                l  = int'(bp.upd_meta[2*PD+1 -: PD]);
                c  = int'(bp.upd_meta[PD+1 -: PD]);
                pg = bp.upd_meta[1];
                pl = bp.upd_meta[0];
                b  = int'(bp.upd_pc >> 2) % NB;
                gp[g] <= bump(gp[g], t);
                lp[l] <= bump(lp[l], t);
                bh[b] <= (bh[b] * 2 + int'(t)) % NP;
                ghr   <= (ghr * 2 + int'(t)) % (1 << GW);
                if (pg != pl) ch[c] <= bump(ch[c], pl == t);
                if (m_br < PMAX) m_br <= m_br + 1;
                if ((t != bp.upd_pred) && m_miss < PMAX) m_miss <= m_miss + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [MW-1:0] em;
            logic ep;
            model_look(bp.pc_f, bp.mode, em, ep);
            chk("pred", 64'(bp.pred_taken_f), 64'(ep));
            chk("meta", 64'(bp.meta_f), 64'(em));
            chk("mispredict", 64'(bp.mispredict),
                64'(bp.upd_valid & (bp.upd_taken ^ bp.upd_pred)));
            chk("perf_lookup", 64'(bp.perf_lookup), 64'(m_look));
            chk("perf_branch", 64'(bp.perf_branch), 64'(m_br));
            chk("perf_miss", 64'(bp.perf_miss), 64'(m_miss));
        end
    end

    task automatic idle();
        bp.lookup_f  = 1'b0;
        bp.upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Fresh lookup, then resolve in the following cycle with the carried meta.
    task automatic branch(input logic [31:0] pc, input logic t,
                          output logic miss);
        logic [MW-1:0] m;
        logic p;
        bp.pc_f      = pc;
        bp.lookup_f  = 1'b1;
        bp.upd_valid = 1'b0;
        @(negedge clk);
        m = bp.meta_f;
        p = bp.pred_taken_f;
        @(posedge clk);
        #1;
        bp.lookup_f  = 1'b0;
        bp.upd_valid = 1'b1;
        bp.upd_pc    = pc;
        bp.upd_taken = t;
        bp.upd_pred  = p;
        bp.upd_meta  = m;
        @(negedge clk);
        miss = bp.mispredict;
        @(posedge clk);
        #1 bp.upd_valid = 1'b0;
    endtask

    task automatic upd_raw(input logic [MW-1:0] m, input logic [31:0] pc,
                           input logic t, input logic p);
        bp.upd_valid = 1'b1;
        bp.upd_meta  = m;
        bp.upd_pc    = pc;
        bp.upd_taken = t;
        bp.upd_pred  = p;
        @(posedge clk);
        #1 bp.upd_valid = 1'b0;
    endtask

    initial begin
        logic miss;
        int cnt;
        bp.mode      = 2'b00;
        bp.pc_f      = 32'h0040_0010;
        bp.lookup_f  = 1'b0;
        bp.upd_valid = 1'b0;
        bp.upd_pc    = '0;
        bp.upd_taken = 1'b0;
        bp.upd_pred  = 1'b0;
        bp.upd_meta  = '0;
        do_reset();

        // Reset state lookup
        @(negedge clk);
        chk("rst_pred", 64'(bp.pred_taken_f), 64'd0);
        chk("rst_meta", 64'(bp.meta_f), 64'({7'd4, 7'd0, 7'd4, 2'b00}));
        chk("rst_perf", 64'({bp.perf_lookup, bp.perf_branch, bp.perf_miss}), 64'd0);
        @(posedge clk);
        #1;

        // Same branch taken twice, then a probe that lands on trained entries
        branch(32'h0040_0010, 1'b1, miss);
        chk("t2_miss1", 64'(miss), 64'd1);
        branch(32'h0040_0010, 1'b1, miss);
        chk("t2_miss2", 64'(miss), 64'd1);
        bp.pc_f     = 32'h0040_001C;
        bp.lookup_f = 1'b1;
        @(negedge clk);
        chk("t2_probe_pred", 64'(bp.pred_taken_f), 64'd1);
        chk("t2_probe_pgpl", 64'(bp.meta_f[1:0]), 64'd3);
        @(posedge clk);
        #1 bp.lookup_f = 1'b0;
        for (int i = 0; i < 3; i++) branch(32'h0040_0010, 1'b0, miss);
        @(negedge clk);
        chk("t2_perf_miss", 64'(bp.perf_miss), 64'd2);
        chk("t2_perf_branch", 64'(bp.perf_branch), 64'd5);
        chk("t2_perf_lookup", 64'(bp.perf_lookup), 64'd6);
        @(posedge clk);
        #1;

        // Chooser trained toward local on cidx 5
        do_reset();
        for (int i = 0; i < 3; i++)
            upd_raw({7'd40, 7'd7, 7'd5, 2'b01}, 32'h0040_0014, 1'b1, 1'b0);
        bp.pc_f = 32'h0040_0014;
        @(negedge clk);
        chk("t4_choice_local", 64'(bp.pred_taken_f), 64'd1);
        chk("t4_pgpl", 64'(bp.meta_f[1:0]), 64'd1);
        bp.mode = 2'b01;
        #1 chk("t4_global_only", 64'(bp.pred_taken_f), 64'd0);
        bp.mode = 2'b11;
        #1 chk("t4_static_nt", 64'(bp.pred_taken_f), 64'd0);
        @(posedge clk);
        #1 bp.mode = 2'b00;

        // Same-cycle lookup and update of gidx 4
        do_reset();
        bp.mode = 2'b01;
        upd_raw({7'd4, 7'd0, 7'd0, 2'b00}, 32'h0040_0000, 1'b1, 1'b0);
        bp.pc_f      = 32'h0040_0014;
        bp.lookup_f  = 1'b1;
        bp.upd_valid = 1'b1;
        bp.upd_meta  = {7'd4, 7'd0, 7'd0, 2'b00};
        bp.upd_pc    = 32'h0040_0000;
        bp.upd_taken = 1'b0;
        bp.upd_pred  = 1'b0;
        @(negedge clk);
        chk("t5_old_value", 64'(bp.pred_taken_f), 64'd1);
        @(posedge clk);
        #1;
        bp.upd_valid = 1'b0;
        bp.pc_f      = 32'h0040_0018;
        @(negedge clk);
        chk("t5_gidx_same", 64'(bp.meta_f[MW-1 -: PD]), 64'd4);
        chk("t5_new_value", 64'(bp.pred_taken_f), 64'd0);
        @(posedge clk);
        #1 bp.lookup_f = 1'b0;

        // Loop branch TTTN, local only then global only
        do_reset();
        bp.mode = 2'b10;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            branch(32'h0040_0020, (i % 4) != 3, miss);
            if (i >= 40 && miss) cnt++;
        end
        chk("t3_local_miss", 64'(cnt), 64'd0);
        bp.mode = 2'b01;
        for (int i = 0; i < 40; i++)
            branch(32'h0040_0020, (i % 4) != 3, miss);

        // Perf saturation and asynchronous reset
        do_reset();
        bp.mode = 2'b00;
        for (int i = 0; i < 16; i++)
            upd_raw('0, 32'h0040_0030, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_sat15", 64'(bp.perf_miss), 64'd15);
        @(posedge clk);
        #1;
        upd_raw('0, 32'h0040_0030, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_hold15", 64'(bp.perf_miss), 64'd15);
        chk("t6_branch15", 64'(bp.perf_branch), 64'd15);
        @(posedge clk);
        #2;
        bp.upd_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_miss", 64'(bp.perf_miss), 64'd0);
        chk("t6_async_branch", 64'(bp.perf_branch), 64'd0);
        chk("t6_async_lookup", 64'(bp.perf_lookup), 64'd0);
        bp.upd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
